// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants for the dpram streaming FIFO controller: default geometry
// and the depth of the output skid buffer.
package dpram_fifo_ctrl_pkg;

  localparam int DEF_AWIDTH       = 11;
  localparam int DEF_NUM_WORDS    = 2048;
  localparam int DEF_DWIDTH       = 40;
  localparam int DEF_AFULL_THRESH = 2040;
  localparam int SKID_DEPTH       = 2;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer valid-ready streams of the dpram FIFO controller.
// The controller takes the slave view; the surrounding logic takes the master view.
interface dpram_fifo_ctrl_if
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
);

  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dpram_fifo_skid.sv
// Two-entry output buffer that absorbs the one-cycle RAM read latency.
// Entry 0 is always the head; a capture with a pop in the same cycle shifts.
module dpram_fifo_skid
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] head,
  output logic [1:0]        cnt
);

  logic [DWIDTH-1:0] ent0_q, ent0_d;
  logic [DWIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({wr_en, rd_en})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = wr_data;
        end else begin
          ent1_d = wr_data;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = wr_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = wr_data;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = ent0_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller wrapping a 2048x40 dual-port RAM (write on port A, read on port B).
// Optional sticky overflow detection is built when DPRAM_FIFO_ERR_EN is defined.
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int NUM_WORDS    = DEF_NUM_WORDS,
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic              clk,
  input  logic              resetn,
  dpram_fifo_ctrl_if.slave  bus_if,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic              empty,
  output logic [AWIDTH-1:0] ram_address_a,
  output logic              ram_wren_a,
  output logic [DWIDTH-1:0] ram_data_a,
  output logic [AWIDTH-1:0] ram_address_b,
  output logic              ram_wren_b,
  input  logic [DWIDTH-1:0] ram_out_b,
  output logic              err_overflow
);

  localparam logic [AWIDTH:0] FULL_CNT  = (AWIDTH+1)'(NUM_WORDS);
  localparam logic [AWIDTH:0] AFULL_CNT = (AWIDTH+1)'(AFULL_THRESH);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic              rd_inflight_q, rd_inflight_d;

  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              rd_issue;
  logic [2:0]        skid_room;
  logic [1:0]        skid_cnt;
  logic [DWIDTH-1:0] skid_head;

  // Issue a read only if the word will still fit in the skid after this cycle's pop.
  always_comb begin
    in_ready      = (ram_cnt_q != FULL_CNT);
    out_valid     = (skid_cnt != 2'd0);
    push          = bus_if.in_valid & in_ready;
    pop           = out_valid & bus_if.out_ready;
    skid_room     = {1'b0, skid_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
    rd_issue      = (ram_cnt_q != '0) & (skid_room < 3'(SKID_DEPTH));
    wr_ptr_d      = push ? (wr_ptr_q + AWIDTH'(1)) : wr_ptr_q;
    rd_ptr_d      = rd_issue ? (rd_ptr_q + AWIDTH'(1)) : rd_ptr_q;
    rd_inflight_d = rd_issue;
    case ({push, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + (AWIDTH+1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (AWIDTH+1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  dpram_fifo_skid #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (rd_inflight_q),
    .wr_data (ram_out_b),
    .rd_en   (pop),
    .head    (skid_head),
    .cnt     (skid_cnt)
  );

  assign bus_if.in_ready  = in_ready;
  assign bus_if.out_valid = out_valid;
  assign bus_if.out_data  = skid_head;

  assign count       = ram_cnt_q + (AWIDTH+1)'(rd_inflight_q) + (AWIDTH+1)'(skid_cnt);
  assign almost_full = (count >= AFULL_CNT);
  assign empty       = (count == '0);

  assign ram_address_a = wr_ptr_q;
  assign ram_wren_a    = push;
  assign ram_data_a    = bus_if.in_data;
  assign ram_address_b = rd_ptr_q;
  assign ram_wren_b    = 1'b0;

`ifdef DPRAM_FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (bus_if.in_valid & ~in_ready & almost_full);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_overflow = err_q;
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural dual-port RAM and a queue scoreboard.
// Builds with or without DPRAM_FIFO_ERR_EN.
module tb_dpram_fifo_ctrl;
  import dpram_fifo_ctrl_pkg::*;

  localparam int AW = DEF_AWIDTH;
  localparam int DW = DEF_DWIDTH;
`ifdef DPRAM_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW:0]   count;
  logic          almost_full, empty, err_overflow;
  logic [AW-1:0] ram_address_a, ram_address_b;
  logic          ram_wren_a, ram_wren_b;
  logic [DW-1:0] ram_data_a, ram_out_b;

  always #5 clk = ~clk;

  dpram_fifo_ctrl_if bus ();

  dpram_fifo_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus_if        (bus),
    .count         (count),
    .almost_full   (almost_full),
    .empty         (empty),
    .ram_address_a (ram_address_a),
    .ram_wren_a    (ram_wren_a),
    .ram_data_a    (ram_data_a),
    .ram_address_b (ram_address_b),
    .ram_wren_b    (ram_wren_b),
    .ram_out_b     (ram_out_b),
    .err_overflow  (err_overflow)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    ram_out_b <= mem[ram_address_b];
  end

  int            n_checks = 0;
  int            n_err = 0;
  logic [DW-1:0] sb [$];
  int            k;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: occupancy against scoreboard depth, then data on every pop.
  always @(negedge clk) begin
    if (resetn) begin
      chk("count_vs_sb", 64'(count), 64'(sb.size()));
      chk("empty_vs_sb", 64'(empty), 64'(sb.size() == 0));
      chk("afull_vs_sb", 64'(almost_full), 64'(sb.size() >= DEF_AFULL_THRESH));
      chk("wren_b_zero", 64'(ram_wren_b), 64'd0);
      chk("wren_a_push", 64'(ram_wren_a), 64'(bus.in_valid & bus.in_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 64'd1, 64'd0);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(sb.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (empty) break;
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_no_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    resetn        = 1'b0;
    step();
    step();
    sb.delete();
    resetn = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_err", 64'(err_overflow), 64'd0);

    // Single word latency
    bus.out_ready = 1'b1;
    bus.in_data   = 40'h00_0000_0001;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid_e0", 64'(bus.out_valid), 64'd0);
    step();
    chk("t1_valid_e1", 64'(bus.out_valid), 64'd0);
    step();
    chk("t1_valid_e2", 64'(bus.out_valid), 64'd1);
    chk("t1_data", 64'(bus.out_data), 64'h1);
    step();
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);

    // Fill to capacity with the consumer stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    k = 0;
    bus.in_data = DW'(k);
    for (int i = 0; i < 3000 && bus.in_ready; i++) begin
      step();
      k++;
      bus.in_data = DW'(k);
    end
    chk("t2_accepted", 64'(k), 64'd2050);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t2_count", 64'(count), 64'd2050);
    chk("t2_afull", 64'(almost_full), 64'd1);
    step();
    chk("t2_err", 64'(err_overflow), 64'(ERR_EXP));
    chk("t2_count_hold", 64'(count), 64'd2050);

    // Pop at full: in_ready rises one cycle later, then push+pop holds count
    bus.out_ready = 1'b1;
    step();
    chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_count_drop", 64'(count), 64'd2049);
    for (int i = 0; i < 4; i++) begin
      k++;
      bus.in_data = DW'(k);
      step();
      chk("t6_count_hold", 64'(count), 64'd2049);
      chk("t6_ready_hold", 64'(bus.in_ready), 64'd1);
    end
    drain();

    // Sustained streaming across pointer wrap
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      bus.in_data = DW'(32'h0001_0000 + i);
      step();
      chk("t3_out_valid", 64'(bus.out_valid), (i < 2) ? 64'd0 : 64'd1);
      chk("t3_in_ready", 64'(bus.in_ready), 64'd1);
    end
    drain();

    // Random producer/consumer traffic
    for (int i = 0; i < 20000; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = $urandom_range(0, 1) == 1;
      bus.in_data   = DW'({$urandom(), $urandom()});
      step();
    end
    drain();

    // Reset with 100 words held and a read in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_data = DW'(40'h500 + i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    resetn = 1'b0;
    step();
    sb.delete();
    resetn = 1'b1;
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_err", 64'(err_overflow), 64'd0);
    bus.in_data   = 40'hAB;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5 && !bus.out_valid; i++) step();
    chk("t5_first_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_first_data", 64'(bus.out_data), 64'hAB);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
